// File: rtl/heap_pkg.sv
// Shared definitions for the pipelined min-heap: entry flags, sentinels,
// controller states and the entry ordering used by root and level nodes.
package heap_pkg;

   localparam logic [1:0] FLAG_NORM = 2'b00;
   localparam logic [1:0] FLAG_MIN  = 2'b01;
   localparam logic [1:0] FLAG_MAX  = 2'b11;

   localparam int DW_DEF = 32;
   localparam logic [DW_DEF-1:0] MAX_DATA  = {FLAG_MAX, {(DW_DEF-2){1'b0}}};
   localparam logic [DW_DEF-1:0] INIT_DATA = {FLAG_MIN, {(DW_DEF-2){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_DRAIN,
      S_HOLD
   } state_e;

   // Sentinels order outside every normal key: MIN below, MAX above.
   function automatic logic cmp_lt(input logic [1:0] fa,
                                   input logic [1:0] fb,
                                   input logic       key_lt);
      logic r;
      r = 1'b0;
      if (fa == FLAG_MAX)
         r = 1'b0;
      else if (fa == FLAG_MIN)
         r = (fb != FLAG_MIN);
      else if (fb == FLAG_MAX)
         r = 1'b1;
      else if (fb == FLAG_MIN)
         r = 1'b0;
      else
         r = key_lt;
      return r;
   endfunction

   function automatic logic cmp_lte(input logic [1:0] fa,
                                    input logic [1:0] fb,
                                    input logic       key_lt,
                                    input logic       key_eq);
      logic same;
      same = (fa == fb) && ((fa != FLAG_NORM) || key_eq);
      return cmp_lt(fa, fb, key_lt) || same;
   endfunction

endpackage

// File: rtl/heap_key_cmp.sv
// Combinational strict less-than between two heap entries,
// given as flag and key fields.
module heap_key_cmp #(
   parameter int KEY_WIDTH = 16
) (
   input  logic [1:0]           flag_a,
   input  logic [KEY_WIDTH-1:0] key_a,
   input  logic [1:0]           flag_b,
   input  logic [KEY_WIDTH-1:0] key_b,
   output logic                 lt
);
   import heap_pkg::*;

   assign lt = cmp_lt(flag_a, flag_b, key_a < key_b);

endmodule

// File: rtl/heap_top_ctrl.sv
// Root controller of the pipelined min-heap: filters candidates against
// the root, issues replace-top sift-downs and drains in ascending order.
module heap_top_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int KEY_WIDTH  = 16,
   parameter int ADDR_WIDTH = 5,
   parameter int LEVELS     = 5,
   parameter logic [DATA_WIDTH-1:0] INIT_DATA =
      {heap_pkg::FLAG_MIN, {(DATA_WIDTH-2){1'b0}}}
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  drain_req,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  drain_done,
   output logic                  busy,
   output logic                  init,
   output logic                  pl_update,
   output logic [ADDR_WIDTH-1:0] pl_addr,
   output logic                  pl_branch,
   output logic [DATA_WIDTH-1:0] pl_data,
   input  logic                  up_we,
   input  logic [ADDR_WIDTH-1:0] up_addr,
   input  logic [DATA_WIDTH-1:0] up_data
);
   import heap_pkg::*;

   localparam int INIT_CYCLES = (1 << LEVELS) + 2;
   localparam int CW = $clog2(INIT_CYCLES + 1);
   localparam int FH = DATA_WIDTH - 1;
   localparam int FL = DATA_WIDTH - 2;
   localparam logic [DATA_WIDTH-1:0] MAX_D =
      {FLAG_MAX, {(DATA_WIDTH-2){1'b0}}};

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] root_q, root_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ret_drain_q, ret_drain_d;
   logic                  drain_pend_q, drain_pend_d;
   logic [1:0]            root_flag;
   logic [1:0]            in_flag;
   logic                  root_lt_in;

   assign root_flag = root_q[FH:FL];
   assign in_flag   = in_data[FH:FL];
   assign busy      = (state_q != S_IDLE);
   assign pl_addr   = '0;
   assign pl_branch = 1'b0;

   heap_key_cmp #(
      .KEY_WIDTH (KEY_WIDTH)
   ) u_cmp (
      .flag_a (root_flag),
      .key_a  (root_q[KEY_WIDTH-1:0]),
      .flag_b (in_flag),
      .key_b  (in_data[KEY_WIDTH-1:0]),
      .lt     (root_lt_in)
   );

   always_comb begin
      state_d      = state_q;
      root_d       = root_q;
      cnt_d        = cnt_q;
      ret_drain_d  = ret_drain_q;
      drain_pend_d = drain_pend_q;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_data     = '0;
      drain_done   = 1'b0;
      init         = 1'b0;
      pl_update    = 1'b0;
      pl_data      = '0;
      if (start) begin
         init         = 1'b1;
         root_d       = INIT_DATA;
         cnt_d        = '0;
         drain_pend_d = 1'b0;
         state_d      = S_INIT;
      end else begin
         unique case (state_q)
            S_IDLE: begin
            end
            S_INIT: begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(INIT_CYCLES - 1))
                  state_d = S_RUN;
            end
            S_RUN: begin
               if (drain_pend_q) begin
                  state_d = S_DRAIN;
               end else begin
                  in_ready = 1'b1;
                  if (drain_req)
                     drain_pend_d = 1'b1;
                  if (in_valid && in_flag == FLAG_NORM && root_lt_in) begin
                     pl_update   = 1'b1;
                     pl_data     = in_data;
                     root_d      = in_data;
                     ret_drain_d = 1'b0;
                     state_d     = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               // Level-1 node returns the new minimum one cycle after issue.
               if (up_we && up_addr == '0)
                  root_d = up_data;
               if (drain_req && !ret_drain_q)
                  drain_pend_d = 1'b1;
               state_d = (drain_pend_q || ret_drain_q) ? S_DRAIN : S_RUN;
            end
            S_DRAIN: begin
               if (root_flag == FLAG_MAX) begin
                  drain_done   = 1'b1;
                  drain_pend_d = 1'b0;
                  state_d      = S_IDLE;
               end else if (root_flag != FLAG_NORM || out_ready) begin
                  out_valid   = (root_flag == FLAG_NORM);
                  out_data    = out_valid ? root_q : '0;
                  pl_update   = 1'b1;
                  pl_data     = MAX_D;
                  root_d      = MAX_D;
                  ret_drain_d = 1'b1;
                  state_d     = S_HOLD;
               end else begin
                  out_valid = 1'b1;
                  out_data  = root_q;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         root_q       <= INIT_DATA;
         cnt_q        <= '0;
         ret_drain_q  <= 1'b0;
         drain_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         root_q       <= root_d;
         cnt_q        <= cnt_d;
         ret_drain_q  <= ret_drain_d;
         drain_pend_q <= drain_pend_d;
      end
   end

endmodule
